dmem_responder: RTL and testbench

- Memory-side responder for the processor's 4B val/rdy memory interface; the target end of `imemreq`/`dmemreq` traffic.
- Accepts `mem_req_4B_t` read, write and init requests into a word-addressed storage array.
- Returns `mem_resp_4B_t` responses through a 2-entry response queue.
- Used as the instruction/data memory in processor test harnesses, with programmable fixed latency for stall testing.

---
 rtl/dmem_responder_pkg.sv | 39 +++
 rtl/dmem_responder_resp_queue.sv | 50 +++++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: request type and test-code encodings plus the 4B memory
// message layouts shared by the responder and its response queue.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2
  } mem_type_e;

  typedef enum logic [1:0] {
    TEST_OK  = 2'd0,
    TEST_ERR = 2'd1
  } mem_test_e;

  localparam int unsigned c_req_nbits  = 77;
  localparam int unsigned c_resp_nbits = 47;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic int unsigned calc_addr_bits(input int unsigned nbytes);
    return $clog2(nbytes);
  endfunction

endpackage

// File: rtl/dmem_responder_resp_queue.sv
// dmem_responder_resp_queue: 2-entry response FIFO; slot0 is always the head.
module dmem_responder_resp_queue
  import dmem_responder_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [c_resp_nbits-1:0] push_data,
  input  logic                    pop,
  output logic [c_resp_nbits-1:0] head,
  output logic [1:0]              count,
  output logic                    full,
  output logic                    empty
);

  logic [c_resp_nbits-1:0] slot0;
  logic [c_resp_nbits-1:0] slot1;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = empty ? '0 : slot0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (empty) slot0 <= push_data;
          else       slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        // Only reachable at count 1: the incoming entry becomes the new head.
        2'b11: slot0 <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed 4B memory target with fixed response latency.
// Defining DMEM_RESPONDER_CHECK_EN enables misalignment/range checking and err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned p_mem_nbytes = 4096,
  parameter int unsigned p_latency    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg,
  output logic        err
);

  localparam int unsigned c_addr_bits = calc_addr_bits(p_mem_nbytes);
  localparam int unsigned c_nwords    = p_mem_nbytes / 4;
  localparam logic [7:0]  c_latency   = 8'(p_latency);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e       state, state_next;
  logic [7:0]   cnt, cnt_next;
  mem_resp_4B_t stash, stash_next;
  mem_req_4B_t  req;
  mem_resp_4B_t resp;

  logic [31:0]            mem [c_nwords];
  logic [c_addr_bits-3:0] idx;
  logic [1:0]             offset;
  logic [2:0]             len_bytes;
  logic [31:0]            rd_word;
  logic [31:0]            rd_mask;
  logic [31:0]            rd_data;
  logic [31:0]            wr_shift;
  logic [3:0]             wr_en;
  logic                   is_read;
  logic                   is_write;
  logic                   bad;
  logic                   accept;
  logic                   do_write;

  logic                    q_push;
  logic [c_resp_nbits-1:0] q_push_data;
  logic                    q_full;
  logic                    q_empty;
  logic [1:0]              unused_q_count;
  logic                    unused_addr_hi;

  assign req            = memreq_msg;
  assign idx            = req.addr[c_addr_bits-1:2];
  assign offset         = req.addr[1:0];
  assign len_bytes      = (req.len == 2'd0) ? 3'd4 : {1'b0, req.len};
  assign rd_word        = mem[idx];
  assign unused_addr_hi = ^req.addr[31:c_addr_bits];

  assign is_read  = (req.msg_type == MEM_READ);
  assign is_write = (req.msg_type == MEM_WRITE) || (req.msg_type == MEM_INIT);

  assign memreq_rdy  = !reset && (state == IDLE) && !q_full;
  assign accept      = memreq_val && memreq_rdy;
  assign do_write    = accept && is_write && !bad;
  assign memresp_val = !q_empty;

`ifdef DMEM_RESPONDER_CHECK_EN
  assign bad = (({1'b0, offset} + len_bytes) > 3'd4) || (req.addr >= 32'(p_mem_nbytes));

  always_ff @(posedge clk) begin
    if (reset)             err <= 1'b0;
    else if (accept && bad) err <= 1'b1;
  end
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    rd_mask = '1;
    unique case (req.len)
      2'd1:    rd_mask = 32'h0000_00FF;
      2'd2:    rd_mask = 32'h0000_FFFF;
      2'd3:    rd_mask = 32'h00FF_FFFF;
      default: rd_mask = '1;
    endcase
    rd_data  = (rd_word >> {offset, 3'b000}) & rd_mask;
    wr_shift = req.data << {offset, 3'b000};
    // Bytes past the end of the word are dropped, so unaligned writes truncate.
    for (int unsigned b = 0; b < 4; b++) begin
      wr_en[b] = (4'(b) >= {2'b00, offset}) &&
                 (4'(b) < ({2'b00, offset} + {1'b0, len_bytes}));
    end
  end

  always_comb begin
    resp          = '0;
    resp.msg_type = req.msg_type;
    resp.opaque   = req.opaque;
    resp.len      = req.len;
    resp.test     = bad ? TEST_ERR : TEST_OK;
    if (is_read && !bad) resp.data = rd_data;
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_en[b]) mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      stash <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      stash <= stash_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stash_next  = stash;
    q_push      = 1'b0;
    q_push_data = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (c_latency == 8'd0) begin
            q_push      = 1'b1;
            q_push_data = resp;
          end else begin
            state_next = WAIT;
            cnt_next   = c_latency;
            stash_next = resp;
          end
        end
      end
      WAIT: begin
        if (cnt == 8'd1) begin
          q_push      = 1'b1;
          q_push_data = stash;
          state_next  = IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  dmem_responder_resp_queue u_resp_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (memresp_rdy),
    .head      (memresp_msg),
    .count     (unused_q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench over three responders (latency 0, 3, 5)
// sharing one request/response channel selected by sel.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        req_val  = 1'b0;
  logic [76:0] req_msg  = '0;
  logic        resp_rdy = 1'b1;
  int unsigned sel      = 0;

  logic [2:0]  val_v, rdy_v, rval_v, err_v;
  logic [46:0] rmsg_v [3];
  logic        rdy, rval, err;
  logic [46:0] rmsg;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) val_v[k] = req_val && (sel == k);
    rdy  = rdy_v[sel];
    rval = rval_v[sel];
    err  = err_v[sel];
    rmsg = rmsg_v[sel];
  end

  dmem_responder #(.p_mem_nbytes(8192), .p_latency(0)) u_lat0 (
    .clk(clk), .reset(reset), .memreq_val(val_v[0]), .memreq_rdy(rdy_v[0]),
    .memreq_msg(req_msg), .memresp_val(rval_v[0]), .memresp_rdy(resp_rdy),
    .memresp_msg(rmsg_v[0]), .err(err_v[0]));

  dmem_responder #(.p_mem_nbytes(8192), .p_latency(3)) u_lat3 (
    .clk(clk), .reset(reset), .memreq_val(val_v[1]), .memreq_rdy(rdy_v[1]),
    .memreq_msg(req_msg), .memresp_val(rval_v[1]), .memresp_rdy(resp_rdy),
    .memresp_msg(rmsg_v[1]), .err(err_v[1]));

  dmem_responder #(.p_mem_nbytes(8192), .p_latency(5)) u_lat5 (
    .clk(clk), .reset(reset), .memreq_val(val_v[2]), .memreq_rdy(rdy_v[2]),
    .memreq_msg(req_msg), .memresp_val(rval_v[2]), .memresp_rdy(resp_rdy),
    .memresp_msg(rmsg_v[2]), .err(err_v[2]));

  // Cycle counter and response monitor; everything is sampled on the falling edge.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [46:0] obs_q [$];
  int unsigned obs_cyc [$];
  logic [46:0] exp_q [$];
  int unsigned rdy_low = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rval && resp_rdy) begin
        obs_q.push_back(rmsg);
        obs_cyc.push_back(cyc);
      end
      if (!rdy) rdy_low <= rdy_low + 1;
    end
  end

  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] a, input logic [1:0] l,
                                         input logic [31:0] d);
    return {t, op, a, l, d};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [2:0] t, input logic [7:0] op,
                                          input logic [1:0] ts, input logic [1:0] l,
                                          input logic [31:0] d);
    return {t, op, ts, l, d};
  endfunction

  // Presents one request and waits (bounded) for the handshake; acc is the cycle it was seen ready.
  task automatic issue(input logic [76:0] m, output bit ok, output int unsigned acc);
    req_msg = m;
    req_val = 1'b1;
    ok      = 1'b0;
    acc     = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (rdy) begin
        ok  = 1'b1;
        acc = cyc;
      end
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_obs(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_queues();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    sel      = 0;
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      compared++;
      if (rdy_v[k] !== 1'b0 || rval_v[k] !== 1'b0 || rmsg_v[k] !== 47'd0 || err_v[k] !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_outputs[%0d]: rdy=%b val=%b msg=%h err=%b, expected all zero",
                 k, rdy_v[k], rval_v[k], rmsg_v[k], err_v[k]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int unsigned k = 0; k < 3; k++) begin
      compared++;
      if (rdy_v[k] !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_rdy[%0d]: got %b expected 1", k, rdy_v[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit          ok0, ok1;
    int unsigned a0, a1, low0;
    logic [46:0] o, e;
    sel      = 0;
    resp_rdy = 1'b1;
    low0     = rdy_low;
    issue(mk_req(3'd1, 8'h05, 32'h1000, 2'd0, 32'hDEADBEEF), ok0, a0);
    exp_q.push_back(mk_resp(3'd1, 8'h05, 2'd0, 2'd0, 32'h0));
    issue(mk_req(3'd0, 8'h06, 32'h1000, 2'd0, 32'h0), ok1, a1);
    exp_q.push_back(mk_resp(3'd0, 8'h06, 2'd0, 2'd0, 32'hDEADBEEF));
    wait_obs(2, 20);
    compared++;
    if (!(ok0 && ok1) || a1 != a0 + 1) begin
      mismatched++;
      $display("FAIL basic_b2b_accept: ok=%b%b cycles %0d,%0d expected consecutive", ok0, ok1, a0, a1);
    end
    compared++;
    if (rdy_low != low0) begin
      mismatched++;
      $display("FAIL basic_rdy_steady: rdy low for %0d cycles, expected 0", rdy_low - low0);
    end
    if (obs_cyc.size() >= 2) begin
      compared++;
      if (obs_cyc[0] != a0 + 1 || obs_cyc[1] != obs_cyc[0] + 1) begin
        mismatched++;
        $display("FAIL basic_timing: resp cycles %0d,%0d accept %0d, expected %0d,%0d",
                 obs_cyc[0], obs_cyc[1], a0, a0 + 1, a0 + 2);
      end
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL basic_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL basic_resp: got %h expected %h", o, e);
      end
    end
    flush_queues();
  endtask

  task automatic test_subword();
    bit          ok;
    int unsigned a, nbad;
    logic [46:0] o, e;
    logic [76:0] reqs [$];
    sel      = 0;
    resp_rdy = 1'b1;
    nbad     = 0;
    reqs.push_back(mk_req(3'd1, 8'h10, 32'h1000, 2'd0, 32'h11223344));
    exp_q.push_back(mk_resp(3'd1, 8'h10, 2'd0, 2'd0, 32'h0));
    reqs.push_back(mk_req(3'd1, 8'h11, 32'h1002, 2'd1, 32'h000000AB));
    exp_q.push_back(mk_resp(3'd1, 8'h11, 2'd0, 2'd1, 32'h0));
    reqs.push_back(mk_req(3'd0, 8'h12, 32'h1000, 2'd0, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h12, 2'd0, 2'd0, 32'h11AB3344));
    reqs.push_back(mk_req(3'd0, 8'h13, 32'h1002, 2'd2, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h13, 2'd0, 2'd2, 32'h000011AB));
    reqs.push_back(mk_req(3'd0, 8'h14, 32'h1003, 2'd1, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h14, 2'd0, 2'd1, 32'h00000011));
    reqs.push_back(mk_req(3'd2, 8'h15, 32'h1004, 2'd0, 32'h0A0B0C0D));
    exp_q.push_back(mk_resp(3'd2, 8'h15, 2'd0, 2'd0, 32'h0));
    reqs.push_back(mk_req(3'd0, 8'h16, 32'h1005, 2'd3, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h16, 2'd0, 2'd3, 32'h000A0B0C));
    reqs.push_back(mk_req(3'd5, 8'h17, 32'h1000, 2'd0, 32'hFFFFFFFF));
    exp_q.push_back(mk_resp(3'd5, 8'h17, 2'd0, 2'd0, 32'h0));
    reqs.push_back(mk_req(3'd0, 8'h18, 32'h1000, 2'd0, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h18, 2'd0, 2'd0, 32'h11AB3344));
`ifndef DMEM_RESPONDER_CHECK_EN
    reqs.push_back(mk_req(3'd0, 8'h19, 32'h3000, 2'd0, 32'h0));
    exp_q.push_back(mk_resp(3'd0, 8'h19, 2'd0, 2'd0, 32'h11AB3344));
`endif
    foreach (reqs[i]) begin
      issue(reqs[i], ok, a);
      if (!ok) nbad++;
    end
    wait_obs(reqs.size(), 30);
    compared++;
    if (nbad != 0) begin
      mismatched++;
      $display("FAIL subword_accept: %0d requests not accepted, expected 0", nbad);
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL subword_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL subword_resp: got %h expected %h", o, e);
      end
    end
    flush_queues();
  endtask

  task automatic test_latency();
    bit          ok;
    int unsigned a;
    logic [46:0] o, e;
    sel      = 1;
    resp_rdy = 1'b1;
    issue(mk_req(3'd1, 8'h21, 32'h0040, 2'd0, 32'h0BADF00D), ok, a);
    exp_q.push_back(mk_resp(3'd1, 8'h21, 2'd0, 2'd0, 32'h0));
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      compared++;
      if (rval !== (k == 4) || rdy !== (k == 4)) begin
        mismatched++;
        $display("FAIL latency_window[%0d]: val=%b rdy=%b expected %b/%b", k, rval, rdy, k == 4, k == 4);
      end
    end
    wait_obs(1, 10);
    compared++;
    if (!ok || obs_cyc.size() < 1 || obs_cyc[0] != a + 4) begin
      mismatched++;
      $display("FAIL latency_write: ok=%b responses=%0d, expected response 4 cycles after accept", ok, obs_cyc.size());
    end
    obs_cyc.delete();
    issue(mk_req(3'd0, 8'h22, 32'h0040, 2'd0, 32'h0), ok, a);
    exp_q.push_back(mk_resp(3'd0, 8'h22, 2'd0, 2'd0, 32'h0BADF00D));
    wait_obs(2, 12);
    compared++;
    if (!ok || obs_cyc.size() < 1 || obs_cyc[0] != a + 4) begin
      mismatched++;
      $display("FAIL latency_read: ok=%b responses=%0d, expected response 4 cycles after accept", ok, obs_cyc.size());
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL latency_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL latency_resp: got %h expected %h", o, e);
      end
    end
    flush_queues();
  endtask

  task automatic test_backpressure();
    bit          ok0, ok1, ok2;
    int unsigned a;
    logic [46:0] o, e, head_exp;
    sel      = 0;
    resp_rdy = 1'b1;
    issue(mk_req(3'd1, 8'h30, 32'h1008, 2'd0, 32'hCAFEF00D), ok0, a);
    issue(mk_req(3'd1, 8'h31, 32'h100C, 2'd0, 32'h01020304), ok1, a);
    wait_obs(2, 20);
    flush_queues();
    resp_rdy = 1'b0;
    issue(mk_req(3'd0, 8'h32, 32'h1008, 2'd0, 32'h0), ok0, a);
    head_exp = mk_resp(3'd0, 8'h32, 2'd0, 2'd0, 32'hCAFEF00D);
    exp_q.push_back(head_exp);
    issue(mk_req(3'd0, 8'h33, 32'h100C, 2'd0, 32'h0), ok1, a);
    exp_q.push_back(mk_resp(3'd0, 8'h33, 2'd0, 2'd0, 32'h01020304));
    compared++;
    if (!(ok0 && ok1)) begin
      mismatched++;
      $display("FAIL bp_first_two: accepted=%b%b expected 11", ok0, ok1);
    end
    req_msg = mk_req(3'd0, 8'h34, 32'h1008, 2'd0, 32'h0);
    req_val = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (rdy !== 1'b0 || rval !== 1'b1 || rmsg !== head_exp) begin
        mismatched++;
        $display("FAIL bp_full[%0d]: rdy=%b val=%b head=%h expected 0/1/%h", k, rdy, rval, rmsg, head_exp);
      end
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    ok2 = 1'b0;
    for (int i = 0; i < 20 && !ok2; i++) begin
      @(negedge clk);
      if (rdy) ok2 = 1'b1;
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    exp_q.push_back(mk_resp(3'd0, 8'h34, 2'd0, 2'd0, 32'hCAFEF00D));
    wait_obs(3, 20);
    compared++;
    if (!ok2) begin
      mismatched++;
      $display("FAIL bp_third_accept: got not accepted expected accepted after drain");
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL bp_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL bp_order: got %h expected %h", o, e);
      end
    end
    flush_queues();
  endtask

  task automatic test_reset_wait();
    bit          ok;
    int unsigned a, stray;
    logic [46:0] o, e;
    sel      = 2;
    resp_rdy = 1'b1;
    issue(mk_req(3'd1, 8'h41, 32'h0020, 2'd0, 32'h00000055), ok, a);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (rdy !== 1'b1 || rval !== 1'b0 || rmsg !== 47'd0 || err !== 1'b0) begin
      mismatched++;
      $display("FAIL rstwait_outputs: rdy=%b val=%b msg=%h err=%b expected 1/0/0/0", rdy, rval, rmsg, err);
    end
    stray = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rval) stray++;
    end
    compared++;
    if (stray != 0 || obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL rstwait_dropped: %0d valid cycles %0d responses, expected 0", stray, obs_q.size());
    end
    flush_queues();
    @(posedge clk);
    #1;
    issue(mk_req(3'd0, 8'h42, 32'h0020, 2'd0, 32'h0), ok, a);
    exp_q.push_back(mk_resp(3'd0, 8'h42, 2'd0, 2'd0, 32'h00000055));
    wait_obs(1, 20);
    compared++;
    if (!ok || obs_cyc.size() < 1 || obs_cyc[0] != a + 6) begin
      mismatched++;
      $display("FAIL rstwait_latency: ok=%b responses=%0d, expected response 6 cycles after accept", ok, obs_cyc.size());
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL rstwait_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL rstwait_resp: got %h expected %h", o, e);
      end
    end
    flush_queues();
  endtask

`ifdef DMEM_RESPONDER_CHECK_EN
  task automatic test_check();
    bit          ok;
    int unsigned a;
    logic [46:0] o, e;
    sel      = 0;
    resp_rdy = 1'b1;
    issue(mk_req(3'd1, 8'h50, 32'h1000, 2'd0, 32'h11223344), ok, a);
    exp_q.push_back(mk_resp(3'd1, 8'h50, 2'd0, 2'd0, 32'h0));
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL check_err_clear: got %b expected 0", err);
    end
    issue(mk_req(3'd1, 8'h51, 32'h1001, 2'd0, 32'hFFFFFFFF), ok, a);
    exp_q.push_back(mk_resp(3'd1, 8'h51, 2'd1, 2'd0, 32'h0));
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL check_err_set: got %b expected 1", err);
    end
    issue(mk_req(3'd0, 8'h52, 32'h1000, 2'd0, 32'h0), ok, a);
    exp_q.push_back(mk_resp(3'd0, 8'h52, 2'd0, 2'd0, 32'h11223344));
    issue(mk_req(3'd0, 8'h53, 32'h2000, 2'd0, 32'h0), ok, a);
    exp_q.push_back(mk_resp(3'd0, 8'h53, 2'd1, 2'd0, 32'h0));
    wait_obs(4, 30);
    repeat (5) @(posedge clk);
    @(negedge clk);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL check_err_sticky: got %b expected 1", err);
    end
    compared++;
    if (obs_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL check_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (o !== e) begin
        mismatched++;
        $display("FAIL check_resp: got %h expected %h", o, e);
      end
    end
    flush_queues();
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_subword();
    test_latency();
    test_backpressure();
    test_reset_wait();
`ifdef DMEM_RESPONDER_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
